// File: rtl/line_window_buffer.sv
// Line window buffer: keeps NUM_LINES-1 lines of pixel history in inferred
// RAM and emits one vertical column of NUM_LINES samples per input pixel,
// two cycles after the pixel is accepted.
module line_window_buffer #(
    parameter int DATA_WIDTH  = 8,
    parameter int CHANNELS    = 1,
    parameter int NUM_LINES   = 3,
    parameter int MAX_WIDTH   = 1280,
    parameter int BORDER_MODE = 0
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0]          in_data,
    input  logic                                    in_sof,
    input  logic                                    in_eol,
    input  logic [$clog2(MAX_WIDTH):0]              cfg_width,
    output logic                                    out_valid,
    output logic [NUM_LINES*CHANNELS*DATA_WIDTH-1:0] out_data,
    output logic                                    out_sof,
    output logic                                    out_eol,
    output logic                                    err_width
);

    localparam int CW = CHANNELS * DATA_WIDTH;
    localparam int AW = $clog2(MAX_WIDTH);
    localparam int NB = NUM_LINES - 1;
    localparam int RW = (NUM_LINES > 2) ? $clog2(NUM_LINES) : 1;
    localparam logic [AW:0]   MAXW_V   = (AW + 1)'(MAX_WIDTH);
    localparam logic [RW-1:0] LAST_ROW = RW'(NUM_LINES - 1);

    // Frame position state
    logic [AW-1:0] col;
    logic [RW-1:0] rows;
    logic [AW:0]   width;
    logic          pend_sof;

    // Current-pixel view after a start of frame has been applied
    logic [AW-1:0] cur_col;
    logic [RW-1:0] cur_rows;
    logic [AW:0]   cur_width;
    logic [AW:0]   width_sel;
    logic          at_last;
    logic          line_end;
    logic          emit;

    // First pipeline stage (pixel accepted, RAM read in flight)
    logic          s1_valid;
    logic          s1_emit;
    logic          s1_sof;
    logic          s1_eol;
    logic [CW-1:0] s1_data;
    logic [AW-1:0] s1_col;
    logic [RW-1:0] s1_rows;

    // Line history: effective read data, write data and bypass path
    logic [CW-1:0] eff_old  [NB];
    logic [CW-1:0] wdata    [NB];
    logic [CW-1:0] fwd_data [NB];
    logic          fwd_hit;

    logic [CW-1:0]              col_words [NUM_LINES];
    logic [NUM_LINES*CW-1:0]    out_next;

    // Resolve column, row count and line width for the pixel on the input
    always_comb begin
        width_sel = ((cfg_width == '0) || (cfg_width > MAXW_V)) ? MAXW_V : cfg_width;
        cur_col   = in_sof ? '0 : col;
        cur_rows  = in_sof ? '0 : rows;
        cur_width = in_sof ? width_sel : width;
        at_last   = ({1'b0, cur_col} == (cur_width - 1'b1));
        line_end  = in_eol || at_last;
        emit      = (BORDER_MODE != 0) || (cur_rows == LAST_ROW);
    end

    // Column/row counters, latched width, sticky error and pending frame start
    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            rows      <= '0;
            width     <= MAXW_V;
            err_width <= 1'b0;
            pend_sof  <= 1'b0;
        end else if (in_valid) begin
            if (in_sof) begin
                width <= width_sel;
            end
            col <= line_end ? '0 : cur_col + 1'b1;
            if (line_end && (cur_rows != LAST_ROW)) begin
                rows <= cur_rows + 1'b1;
            end else begin
                rows <= cur_rows;
            end
            if (in_eol != at_last) begin
                err_width <= 1'b1;
            end
            pend_sof <= (in_sof || pend_sof) && !emit;
        end
    end

    // Capture the accepted pixel alongside the RAM read
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= in_valid;
        end
        if (in_valid) begin
            s1_emit <= emit;
            s1_sof  <= emit && (in_sof || pend_sof);
            s1_eol  <= in_eol;
            s1_data <= in_data;
            s1_col  <= cur_col;
            s1_rows <= cur_rows;
        end
    end

    // Remember the data being written when the next read hits the same column
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_hit <= 1'b0;
        end else if (in_valid) begin
            fwd_hit <= s1_valid && (s1_col == cur_col);
        end
        if (in_valid) begin
            for (int j = 0; j < NB; j++) begin
                fwd_data[j] <= wdata[j];
            end
        end
    end

    // Shift the column down one bank: newest pixel into bank 0
    always_comb begin
        wdata[0] = s1_data;
        for (int j = 1; j < NB; j++) begin
            wdata[j] = eff_old[j-1];
        end
    end

    for (genvar j = 0; j < NB; j++) begin : g_bank
        logic [CW-1:0] mem [MAX_WIDTH];
        logic [CW-1:0] ram_q;

        // One write (previous pixel) and one read (current pixel) per cycle
        always_ff @(posedge clk) begin
            if (s1_valid) begin
                mem[s1_col] <= wdata[j];
            end
            if (in_valid) begin
                ram_q <= mem[cur_col];
            end
        end

        assign eff_old[j] = fwd_hit ? fwd_data[j] : ram_q;
    end

    // Assemble the output column, replicating the top edge when enabled
    always_comb begin
        col_words[0] = s1_data;
        for (int k = 1; k < NUM_LINES; k++) begin
            col_words[k] = eff_old[k-1];
        end
        out_next = '0;
        for (int k = 0; k < NUM_LINES; k++) begin
            if ((BORDER_MODE != 0) && (k > int'(s1_rows))) begin
                out_next[k*CW +: CW] = col_words[s1_rows];
            end else begin
                out_next[k*CW +: CW] = col_words[k];
            end
        end
    end

    // Output register; everything is zero when no column is presented
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
        end else begin
            out_valid <= s1_valid && s1_emit;
            out_data  <= (s1_valid && s1_emit) ? out_next : '0;
            out_sof   <= s1_valid && s1_emit && s1_sof;
            out_eol   <= s1_valid && s1_emit && s1_eol;
        end
    end

endmodule
